uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each single-cycle received-byte pulse, with its break flag, into a first-word-fall-through FIFO. It presents the bytes to the consumer over a valid/ready stream. Bytes that arrive while the buffer is full are dropped, and a sticky overflow flag records the loss.

## Interface
Parameters:
- DEPTH, 16: number of entries; a power of two, at least 2.
- DATA_W, 8: payload width in bits.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  one-cycle pulse: the receiver completed a byte.
- in_data  in  DATA_W  received byte; qualified by in_valid.
- in_break  in  1  line-break indication; qualified by in_valid.
- out_valid  out  1  head entry available (equals !empty).
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_W  head byte; 0 when empty.
- out_break  out  1  break flag of the head entry; 0 when empty.
- level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: at least one byte has been dropped.
- overflow_clr  in  1  one-cycle pulse that clears overflow.

## Operation
- Each entry is {in_break, in_data}, DATA_W+1 bits wide.
- Push condition: in_valid && (!full || pop), where pop = out_valid && out_ready. If the FIFO is full and a pop happens in the same cycle, the incoming byte is accepted.
- Drop condition: in_valid && full && !pop. The byte is discarded, overflow is set, and pointers and contents are unchanged.
- overflow_clr clears overflow. If overflow_clr and a drop occur in the same cycle, the set wins and overflow stays 1.
- Pop when out_ready is asserted on an empty FIFO has no effect.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- Write and read pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - full: MSBs differ and the remaining bits are equal.
  - empty: the pointers are equal.
- level = wr_ptr − rd_ptr, computed modulo 2·DEPTH, in $clog2(DEPTH)+1 bits.
- A break entry is stored and delivered like any other entry. The data byte of a break entry is 0x00 as received; the FIFO does not alter it.
- in_valid is treated as a pulse. Holding it high for N cycles pushes N entries.

## Timing
- Reset (asynchronous assert; release sampled on clk):
  - out_valid=0, out_data=0, out_break=0
  - level=0, full=0, empty=1, overflow=0
  - pointers at 0; storage contents are not reset
- If reset is asserted mid-operation, all stored entries are discarded immediately and no out_valid glitch occurs after release.
- Write latency: a byte pushed at edge N is visible on out_valid/out_data in the cycle after edge N (one cycle, fall-through).
- Pop: the head is consumed at the edge where out_valid && out_ready. The next entry, if any, appears in the following cycle with no bubble.
- full, empty, level and overflow are registered, or derived only from registered pointers; they update one edge after the event.
- out_data and out_break are combinational from the storage head and the empty flag. There is no combinational path from out_ready to out_valid.
- The push decision depends combinationally on out_ready, because pop frees space when full.

## Structure
- Shared header uart_defs.vh holds:
  - UART_DATA_W (8)
  - UART_RXF_ENTRY_W (UART_DATA_W+1)
  - bit-index constants for the break and data fields of an entry
- Sub-module uart_fifo_mem:
  - DEPTH × ENTRY_W storage, one synchronous write port, one asynchronous read port
  - no reset
  - parameters DEPTH and WIDTH
- The top level holds the pointers, flags, overflow logic and output masking. Target size is about 150–250 lines total.

## Test plan
- Reset mid-stream: push 0x41, 0x42, then assert reset for 1 cycle → out_valid=0, level=0, empty=1, overflow=0. A later push of 0x43 appears as the first output.
- Ordering and latency: push 0x55 at edge N with out_ready=0 → out_valid=1 and out_data=0x55 from cycle N+1. Push 0x01..0x0F → popping returns them in order, level counts down to 0, and empty asserts.
- Full plus drop: with DEPTH=16, push 16 bytes → full=1, level=16. A 17th push of 0xAA without a pop → dropped, overflow=1, and the head is still the first byte. Pulse overflow_clr → overflow=0.
- Simultaneous push and pop when full: push 0xBB while out_ready=1 → accepted, overflow stays 0, level stays 16, and 0xBB is the last byte popped.
- Overflow set/clear collision: assert overflow_clr in the same cycle as a drop → overflow=1.
- Break and wrap: push in_break=1 with in_data=0x00 → out_break=1, out_data=0x00. Then run 40 push/pop pairs through the pointer wrap → data matches exactly and level never exceeds 1.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared field layout for UART receive-buffer entries.
// An entry is {break, data}; the break flag sits directly above the payload.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_RXF_ENTRY_W  = UART_DATA_W + 1;
  localparam int UART_RXF_DATA_LSB = 0;
  localparam int UART_RXF_BRK_BIT  = UART_DATA_W;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through buffer for received UART bytes with break flag.
// Bytes arriving while full are dropped and recorded in a sticky overflow flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_break,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_break,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  // Package layout is expressed for the default payload; rescale it to DATA_W.
  localparam int ENTRY_W  = DATA_W + (UART_RXF_ENTRY_W - UART_DATA_W);
  localparam int BRK_BIT  = DATA_W + (UART_RXF_BRK_BIT - UART_DATA_W);
  localparam int DATA_LSB = UART_RXF_DATA_LSB;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               pop;
  logic               push;
  logic               drop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  always_comb begin
    wr_entry                                = '0;
    wr_entry[BRK_BIT]                       = in_break;
    wr_entry[DATA_LSB +: DATA_W]            = in_data;
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  assign out_data  = empty ? '0   : rd_entry[DATA_LSB +: DATA_W];
  assign out_break = empty ? 1'b0 : rd_entry[BRK_BIT];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_break;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_break;
  logic [LW-1:0]     level;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              overflow_clr;

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0] mq[$];
  logic            m_ovf;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_break     (in_break),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_break    (out_break),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string ctx);
    int n;
    n = mq.size();
    chk({ctx, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    chk({ctx, ".out_data"},  32'(out_data),  (n != 0) ? 32'(mq[0][DATA_W-1:0]) : 32'd0);
    chk({ctx, ".out_break"}, 32'(out_break), (n != 0) ? 32'(mq[0][DATA_W]) : 32'd0);
    chk({ctx, ".level"},     32'(level),     32'(n));
    chk({ctx, ".full"},      32'(full),      32'(n == DEPTH));
    chk({ctx, ".empty"},     32'(empty),     32'(n == 0));
    chk({ctx, ".overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  // One clock: apply inputs, advance the model by the FIFO rules, then check.
  task automatic step(input string ctx, input logic v, input logic [DATA_W-1:0] d,
                      input logic b, input logic rdy, input logic clr);
    logic m_full, m_pop;
    in_valid = v; in_data = d; in_break = b; out_ready = rdy; overflow_clr = clr;
    m_full = (mq.size() == DEPTH);
    m_pop  = (mq.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (m_pop) void'(mq.pop_front());
    if (v && (!m_full || m_pop)) mq.push_back({b, d});
    if (v && m_full && !m_pop) m_ovf = 1'b1;
    else if (clr)              m_ovf = 1'b0;
    in_valid = 1'b0; in_data = '0; in_break = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
    check_state(ctx);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int max_lvl;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_break = 1'b0;
    out_ready = 1'b0; overflow_clr = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("reset");
    reset = 1'b0;

    // Reset mid-stream discards stored bytes immediately
    step("rst_push41", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step("rst_push42", 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    mq.delete(); m_ovf = 1'b0;
    check_state("rst_async");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("rst_release");
    step("rst_push43", 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    step("rst_pop43",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Latency and ordering
    step("lat_push55", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step("lat_hold55", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("lat_pop55",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) step("ord_push", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) step("ord_pop",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step("empty_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Fill, drop, clear, push-while-full-with-pop, set/clear collision
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    step("drop_aa",   1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step("ovf_clr",   1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("full_pp_bb", 1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    step("collide",   1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
    step("ovf_clr2",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Break entry, then push/pop pairs across the pointer wrap
    step("brk_push", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step("brk_pop",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      step("wrap_push", 1'b1, d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      step("wrap_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("wrap_max_level", 32'(max_lvl), 32'd1);

    // Random traffic, biased toward pushing so the full/drop corners are reached
    for (int i = 0; i < 600; i++) begin
      step("rand",
           1'($urandom_range(0, 99) < 60),
           8'($urandom),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70)),
           1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
